stroke_sequencer: RTL and testbench

- Walks the per-digit stroke ROMs (one ROM per digit 0-9; each maps segment index to start/end coordinates and pen state) from segment 0 to the terminal segment.
- Registers each segment and drives the pen actuator, including a settle delay on every pen change.
- Hands each move to the line/motion engine over a valid/ready handshake, then waits for its move_done before advancing.
- Sits between the top-level digit-entry FSM and the motion engine.

---
 rtl/stroke_sequencer_pkg.sv | 29 ++
 rtl/stroke_sequencer_settle.sv | 27 ++
 rtl/stroke_sequencer.sv | 159 +++++++++++++++
 tb/tb_stroke_sequencer.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stroke_sequencer_pkg.sv
// Shared types and constants for the stroke sequencer and its settle timer.
package stroke_sequencer_pkg;

  localparam int COORD_W    = 8;
  localparam int IDX_W      = 5;
  localparam int DIGIT_MAX  = 9;
  localparam int NUM_DIGITS = DIGIT_MAX + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_PEN       = 3'd2,
    S_SETTLE    = 3'd3,
    S_ISSUE     = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_NEXT      = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  // One-hot ROM select for a digit; an out-of-range digit selects nothing.
  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [3:0] d);
    logic [NUM_DIGITS-1:0] oh;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      oh[i] = (d == 4'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/stroke_sequencer_settle.sv
// Down-counter that times the pen actuator settle window.
module pen_settle_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // Load takes priority; otherwise count down while enabled, holding at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/stroke_sequencer.sv
// Walks a digit's stroke ROM segment by segment, drives the pen with a settle
// delay on every pen change, and hands each move to the motion engine.
module stroke_sequencer
  import stroke_sequencer_pkg::*;
#(
  parameter int MAX_SEGS   = 32,
  parameter int PEN_SETTLE = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            digit,
  output logic [IDX_W-1:0]      rom_idx,
  output logic [NUM_DIGITS-1:0] rom_en,
  input  logic [COORD_W-1:0]    rom_sx,
  input  logic [COORD_W-1:0]    rom_sy,
  input  logic [COORD_W-1:0]    rom_ex,
  input  logic [COORD_W-1:0]    rom_ey,
  input  logic                  rom_pen,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [COORD_W-1:0]    cmd_sx,
  output logic [COORD_W-1:0]    cmd_sy,
  output logic [COORD_W-1:0]    cmd_ex,
  output logic [COORD_W-1:0]    cmd_ey,
  input  logic                  move_done,
  output logic                  pen_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_W = (PEN_SETTLE > 1) ? $clog2(PEN_SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(PEN_SETTLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(MAX_SEGS - 1);

  state_t           state;
  state_t           state_next;
  logic [3:0]       digit_q;
  logic             seg_pen;
  logic             bad_start_q;
  logic             settle_load;
  logic             settle_en;
  logic             settle_zero;
  logic [CNT_W-1:0] settle_count;
  logic             accept_start;
  logic             illegal_start;
  logic             pen_change;
  logic             terminal;

  assign accept_start  = start && (state == S_IDLE) && (digit <= 4'(DIGIT_MAX));
  assign illegal_start = start && (state == S_IDLE) && (digit >  4'(DIGIT_MAX));
  assign pen_change    = (seg_pen != pen_out);
  // Segment 0 leaves the origin, so it can never be the terminal segment.
  assign terminal      = !seg_pen && (cmd_ex == '0) && (cmd_ey == '0) && (rom_idx != '0);

  pen_settle_timer #(
    .CNT_W (CNT_W)
  ) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (settle_load),
    .load_val (SETTLE_LOAD),
    .en       (settle_en),
    .count    (settle_count),
    .zero     (settle_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (accept_start) state_next = S_FETCH;
      S_FETCH:     state_next = S_PEN;
      S_PEN:       state_next = pen_change ? S_SETTLE : S_ISSUE;
      S_SETTLE:    if (settle_zero) state_next = S_ISSUE;
      S_ISSUE:     if (cmd_ready) state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (move_done) state_next = S_NEXT;
      S_NEXT: begin
        if (terminal || (rom_idx == LAST_IDX)) state_next = S_DONE;
        else                                   state_next = S_FETCH;
      end
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs; an illegal-digit start reports done without leaving IDLE.
  always_comb begin
    rom_en      = (state == S_FETCH) ? digit_onehot(digit_q) : '0;
    cmd_valid   = (state == S_ISSUE);
    busy        = (state != S_IDLE);
    done        = (state == S_DONE) || bad_start_q;
    settle_load = (state == S_PEN) && pen_change;
    settle_en   = (state == S_SETTLE);
  end

  // Segment datapath, pen actuator, index walk and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q     <= '0;
      rom_idx     <= '0;
      cmd_sx      <= '0;
      cmd_sy      <= '0;
      cmd_ex      <= '0;
      cmd_ey      <= '0;
      seg_pen     <= 1'b0;
      pen_out     <= 1'b0;
      err         <= 1'b0;
      bad_start_q <= 1'b0;
    end else begin
      bad_start_q <= illegal_start;
      case (state)
        S_IDLE: begin
          if (accept_start) begin
            digit_q <= digit;
            err     <= 1'b0;
            rom_idx <= '0;
          end else if (illegal_start) begin
            err <= 1'b1;
          end
        end
        S_FETCH: begin
          cmd_sx  <= rom_sx;
          cmd_sy  <= rom_sy;
          cmd_ex  <= rom_ex;
          cmd_ey  <= rom_ey;
          seg_pen <= rom_pen;
        end
        S_PEN: begin
          if (pen_change) pen_out <= seg_pen;
        end
        S_NEXT: begin
          if (terminal) begin
            pen_out <= 1'b0;
          end else if (rom_idx == LAST_IDX) begin
            err <= 1'b1;
          end else begin
            rom_idx <= rom_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          rom_idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stroke_sequencer.sv
// Directed bench for stroke_sequencer with a small external stroke ROM model.
module tb_stroke_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  digit;
  logic [4:0]  rom_idx;
  logic [9:0]  rom_en;
  logic [7:0]  rom_sx, rom_sy, rom_ex, rom_ey;
  logic        rom_pen;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_sx, cmd_sy, cmd_ex, cmd_ey;
  logic        move_done;
  logic        pen_out;
  logic        busy;
  logic        done;
  logic        err;

  logic        auto_done;
  logic        spur_done;
  logic [32:0] rom_word;

  int checks;
  int errors;

  // monitor state
  logic        mon_clr;
  logic [9:0]  exp_en;
  logic [32:0] acc_log [0:63];
  int          acc_cnt, done_cnt, busy_seen, rom_en_seen, rom_en_bad;
  int          wrap_cnt, max_idx, unstable, gap_cnt, gap;
  int          gaps [0:7];
  bit          meas;
  logic        prev_busy, prev_pen, prev_valid, prev_ready;
  logic [4:0]  prev_idx;
  logic [31:0] prev_word;

  assign move_done = auto_done | spur_done;

  stroke_sequencer #(
    .MAX_SEGS   (32),
    .PEN_SETTLE (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .digit     (digit),
    .rom_idx   (rom_idx),
    .rom_en    (rom_en),
    .rom_sx    (rom_sx),
    .rom_sy    (rom_sy),
    .rom_ex    (rom_ex),
    .rom_ey    (rom_ey),
    .rom_pen   (rom_pen),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_sx    (cmd_sx),
    .cmd_sy    (cmd_sy),
    .cmd_ex    (cmd_ex),
    .cmd_ey    (cmd_ey),
    .move_done (move_done),
    .pen_out   (pen_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Digit 9 strokes {sx,sy,ex,ey,pen}; segment 5 is terminal.
  function automatic logic [32:0] seg9(input int i);
    case (i)
      0:       return {8'd0,   8'd0,   8'd120, 8'd120, 1'b0};
      1:       return {8'd120, 8'd120, 8'd120, 8'd200, 1'b1};
      2:       return {8'd120, 8'd200, 8'd180, 8'd200, 1'b1};
      3:       return {8'd180, 8'd200, 8'd180, 8'd40,  1'b1};
      4:       return {8'd180, 8'd40,  8'd180, 8'd120, 1'b1};
      5:       return {8'd180, 8'd120, 8'd0,   8'd0,   1'b0};
      default: return 33'd0;
    endcase
  endfunction

  // Digit 3 ROM has no terminal segment: every segment is pen down.
  function automatic logic [32:0] seg3(input int i);
    return {8'(i + 1), 8'(i + 2), 8'(i + 3), 8'(i + 4), 1'b1};
  endfunction

  always_comb begin
    rom_word = 33'd0;
    if (rom_en[9])      rom_word = seg9(int'(rom_idx));
    else if (rom_en[3]) rom_word = seg3(int'(rom_idx));
  end
  assign {rom_sx, rom_sy, rom_ex, rom_ey, rom_pen} = rom_word;

  // Motion engine model: move_done pulse a few cycles after each accept.
  initial begin
    auto_done = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) begin
        @(negedge clk);
        @(negedge clk);
        auto_done = 1'b1;
        @(negedge clk);
        auto_done = 1'b0;
      end
    end
  end

  // Passive observer of the DUT outputs.
  initial begin
    acc_cnt = 0; done_cnt = 0; busy_seen = 0; rom_en_seen = 0; rom_en_bad = 0;
    wrap_cnt = 0; max_idx = 0; unstable = 0; gap_cnt = 0; gap = 0; meas = 0;
    prev_busy = 0; prev_pen = 0; prev_valid = 0; prev_ready = 0; prev_idx = 0; prev_word = 0;
    forever begin
      @(negedge clk);
      if (mon_clr) begin
        acc_cnt = 0; done_cnt = 0; busy_seen = 0; rom_en_seen = 0; rom_en_bad = 0;
        wrap_cnt = 0; max_idx = 0; unstable = 0; gap_cnt = 0; gap = 0; meas = 0;
      end else begin
        if (cmd_valid && cmd_ready) begin
          if (acc_cnt < 64) acc_log[acc_cnt] = {cmd_sx, cmd_sy, cmd_ex, cmd_ey, pen_out};
          acc_cnt++;
        end
        if (done) done_cnt++;
        if (busy) busy_seen++;
        if (rom_en != 10'd0) begin
          rom_en_seen++;
          if (rom_en !== exp_en) rom_en_bad++;
        end
        if (busy && prev_busy && (rom_idx < prev_idx)) wrap_cnt++;
        if (int'(rom_idx) > max_idx) max_idx = int'(rom_idx);
        if (meas) begin
          if (cmd_valid) begin
            if (gap_cnt < 8) gaps[gap_cnt] = gap;
            gap_cnt++;
            meas = 0;
          end else begin
            gap++;
          end
        end
        if (busy && (pen_out != prev_pen)) begin
          meas = 1;
          gap  = 1;
        end
        if (prev_valid && !prev_ready && cmd_valid &&
            ({cmd_sx, cmd_sy, cmd_ex, cmd_ey} != prev_word)) unstable++;
      end
      prev_busy  = busy;
      prev_pen   = pen_out;
      prev_valid = cmd_valid;
      prev_ready = cmd_ready;
      prev_idx   = rom_idx;
      prev_word  = {cmd_sx, cmd_sy, cmd_ex, cmd_ey};
    end
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    start     = 1'b0;
    cmd_ready = 1'b0;
    spur_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_mon(input logic [9:0] en);
    exp_en  = en;
    mon_clr = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0;
  endtask

  task automatic start_pulse(input logic [3:0] d);
    @(negedge clk);
    start = 1'b1;
    digit = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_timeout: no done pulse within %0d cycles", name, budget);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_digit9_run(input string name);
    checks++;
    if (acc_cnt !== 6) begin
      errors++;
      $display("FAIL %s_count: got %0d commands, expected 6", name, acc_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (acc_log[i] !== seg9(i)) begin
        errors++;
        $display("FAIL %s_cmd%0d: got %h expected %h", name, i, acc_log[i], seg9(i));
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL %s_done: got %0d pulses, expected 1", name, done_cnt);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL %s_err: got %b expected 0", name, err);
    end
    checks++;
    if (rom_en_bad !== 0) begin
      errors++;
      $display("FAIL %s_rom_en: got %0d bad enables, expected 0", name, rom_en_bad);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rom_idx, rom_en, cmd_valid, pen_out, busy, done, err} !== 20'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h expected 0",
               {rom_idx, rom_en, cmd_valid, pen_out, busy, done, err});
    end
    checks++;
    if ({cmd_sx, cmd_sy, cmd_ex, cmd_ey} !== 32'd0) begin
      errors++;
      $display("FAIL reset_cmd: got %h expected 0", {cmd_sx, cmd_sy, cmd_ex, cmd_ey});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_digit9();
    do_reset();
    clear_mon(10'b10_0000_0000);
    cmd_ready = 1'b1;
    start_pulse(4'd9);
    wait_done(1000, "digit9");
    check_digit9_run("digit9");
    checks++;
    if (gap_cnt !== 2) begin
      errors++;
      $display("FAIL digit9_pen_changes: got %0d expected 2", gap_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (gaps[i] !== 4) begin
        errors++;
        $display("FAIL digit9_settle%0d: got %0d cycles expected 4", i, gaps[i]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL digit9_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    clear_mon(10'b10_0000_0000);
    cmd_ready = 1'b1;
    start_pulse(4'd9);
    n = 0;
    while (acc_cnt < 2 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    cmd_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_valid && n < 200);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (cmd_valid !== 1'b1 || {cmd_sx, cmd_sy, cmd_ex, cmd_ey, 1'b1} !== seg9(2)) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b cmd=%h expected valid=1 cmd=%h",
                 i, cmd_valid, {cmd_sx, cmd_sy, cmd_ex, cmd_ey}, seg9(2)[32:1]);
      end
    end
    @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (cmd_valid !== 1'b0 || acc_cnt !== 3) begin
      errors++;
      $display("FAIL bp_accept: valid=%b accepts=%0d expected valid=0 accepts=3",
               cmd_valid, acc_cnt);
    end
    wait_done(1000, "bp");
    check_digit9_run("bp");
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d changes while stalled, expected 0", unstable);
    end
  endtask

  task automatic test_illegal_digit();
    do_reset();
    clear_mon(10'd0);
    @(negedge clk);
    start = 1'b1;
    digit = 4'd12;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({done, err, busy} !== 3'b110) begin
      errors++;
      $display("FAIL illegal_pulse: done/err/busy=%b expected 110", {done, err, busy});
    end
    @(negedge clk);
    checks++;
    if ({done, err} !== 2'b01) begin
      errors++;
      $display("FAIL illegal_sticky: done/err=%b expected 01", {done, err});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== 1 || busy_seen !== 0 || rom_en_seen !== 0) begin
      errors++;
      $display("FAIL illegal_quiet: done=%0d busy=%0d rom_en=%0d expected 1 0 0",
               done_cnt, busy_seen, rom_en_seen);
    end
    cmd_ready = 1'b1;
    start_pulse(4'd9);
    checks++;
    if ({err, busy} !== 2'b01) begin
      errors++;
      $display("FAIL illegal_clear: err/busy=%b expected 01", {err, busy});
    end
  endtask

  task automatic test_no_terminal();
    do_reset();
    clear_mon(10'b00_0000_1000);
    cmd_ready = 1'b1;
    start_pulse(4'd3);
    wait_done(3000, "noterm");
    checks++;
    if (acc_cnt !== 32) begin
      errors++;
      $display("FAIL noterm_count: got %0d commands expected 32", acc_cnt);
    end
    checks++;
    if (acc_log[0] !== seg3(0) || acc_log[31] !== seg3(31)) begin
      errors++;
      $display("FAIL noterm_cmds: first=%h last=%h expected %h %h",
               acc_log[0], acc_log[31], seg3(0), seg3(31));
    end
    checks++;
    if (err !== 1'b1 || done_cnt !== 1) begin
      errors++;
      $display("FAIL noterm_err: err=%b done=%0d expected 1 1", err, done_cnt);
    end
    checks++;
    if (wrap_cnt !== 0 || max_idx !== 31) begin
      errors++;
      $display("FAIL noterm_idx: wraps=%0d max=%0d expected 0 31", wrap_cnt, max_idx);
    end
  endtask

  task automatic test_reset_in_settle();
    int n;
    do_reset();
    clear_mon(10'b10_0000_0000);
    cmd_ready = 1'b1;
    start_pulse(4'd9);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pen_out && n < 200);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pen_out, cmd_valid, busy, rom_idx} !== 8'd0) begin
      errors++;
      $display("FAIL rst_settle: pen/valid/busy/idx=%b expected 0",
               {pen_out, cmd_valid, busy, rom_idx});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_mon(10'b10_0000_0000);
    start_pulse(4'd9);
    wait_done(1000, "rst_restart");
    check_digit9_run("rst_restart");
  endtask

  task automatic test_spurious();
    int n;
    do_reset();
    clear_mon(10'b10_0000_0000);
    cmd_ready = 1'b0;
    start_pulse(4'd9);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_valid && n < 200);
    spur_done = 1'b1;
    start     = 1'b1;
    digit     = 4'd3;
    @(negedge clk);
    spur_done = 1'b0;
    start     = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b1 || acc_cnt !== 0) begin
      errors++;
      $display("FAIL spur_issue: valid=%b accepts=%0d expected 1 0", cmd_valid, acc_cnt);
    end
    @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    n = 0;
    while (acc_cnt < 3 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    start_pulse(4'd5);
    wait_done(1000, "spur");
    check_digit9_run("spur");
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    mon_clr = 1'b0;
    exp_en  = 10'd0;
    rst_n   = 1'b0;
    start   = 1'b0;
    digit   = 4'd0;
    cmd_ready = 1'b0;
    spur_done = 1'b0;
    test_reset();
    test_digit9();
    test_backpressure();
    test_illegal_digit();
    test_no_terminal();
    test_reset_in_settle();
    test_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
